// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package add_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice index width; a single-slice configuration still needs one bit.
  function automatic int idx_width(input int chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/add_seq_ctrl_add.sv
// Parameterised N-bit ripple-carry adder shared by the sequencer.
module add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Computes a W-bit a+b or a-b one N-bit slice per cycle through a single
// shared ripple adder, with a start/busy/done handshake.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int CHUNKS = W / N;
  localparam int IW     = idx_width(CHUNKS);
  localparam logic [W-1:0] SLICE_MASK = W'({N{1'b1}});

  // Handshake: start is accepted only on a cycle where busy is low; done is a
  // one-cycle pulse while busy is still high, and result/cout/ovf then hold.
  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic          sub_q, sub_d, carry_q, carry_d;
  logic          cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [W-1:0]  b_eff;
  logic [N-1:0]  a_sl, b_sl, add_sum;
  logic          add_cout, last;
  int            sh;

  (* keep_hierarchy = "yes" *)
  add #(.N(N)) u_add (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    b_eff = sub_q ? ~b_q : b_q;
    sh    = int'(idx_q) * N;
    a_sl  = N'(a_q >> sh);
    b_sl  = N'(b_eff >> sh);
    last  = (idx_q == IW'(CHUNKS - 1));

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          idx_d   = '0;
          carry_d = op_sub;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = (result_q & ~(SLICE_MASK << sh)) | (W'(add_sum) << sh);
        carry_d  = add_cout;
        idx_d    = idx_q + IW'(1);
        if (last) begin
          // On the top slice add_sum[N-1] is the new sign bit of the result.
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_eff[W-1]) && (add_sum[N-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It computes a W-bit sum or difference over W/N clock cycles using one shared N-bit ripple adder instance. A flop carries the carry between N-bit slices. It provides a start/busy/done handshake to the surrounding datapath, so a wide operation costs one narrow adder instead of a W-bit carry chain.

Parameters:
N, 4, adder slice width in bits (width of the shared adder instance)
W, 16, operand/result width in bits; must be an integer multiple of N, W >= N
CHUNKS, W/N, derived localparam; number of RUN cycles per operation

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; accepted only while busy=0
op_sub  input  1  0: a+b, 1: a-b; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high while an accepted operation is in progress (RUN or DONE)
done  output  1  one-cycle pulse; result, cout and ovf are valid
result  output  W  sum or difference; holds its value until the next accepted start or reset
cout  output  1  final carry out; for subtract, 1 = no borrow
ovf  output  1  two's-complement signed overflow of the full W-bit operation

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; result=0, cout=0, ovf=0, done=0, busy=0, slice index=0, carry flop=0.
  - Reset takes priority over start and over any operation in progress.
  - Mid-operation reset aborts the operation and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Latch a, b and op_sub.
  - Set index=0 and carry=op_sub.
  - Go to RUN.
- RUN, each cycle:
  - Adder inputs: a_reg[idx*N +: N]; b_reg[idx*N +: N], bitwise-inverted when op_sub=1; carry flop.
  - At the edge: write the adder sum to result[idx*N +: N] and the adder cout to the carry flop, then increment idx.
  - When idx==CHUNKS-1, the same edge loads cout from the adder, computes ovf and goes to DONE.
- ovf rule: let b_eff be the W-bit (possibly inverted) B. ovf = (a_reg[W-1] == b_eff[W-1]) && (new result[W-1] != a_reg[W-1]).
- DONE: done=1 for exactly this cycle; busy=1; unconditional move to IDLE on the next edge.
- busy = (state != IDLE). start while busy is ignored and does not disturb the latched operands.
- Latency: start high in cycle 0 is sampled at the end of cycle 0. RUN occupies cycles 1..CHUNKS, and done is high in cycle CHUNKS+1. For N=4, W=16, done is in cycle 5.
- If start is held high continuously, a new operation is accepted in the IDLE cycle after DONE. Throughput is one operation per CHUNKS+2 cycles.
- result bits are updated slice by slice during RUN. result is only guaranteed consistent when done=1 and afterwards.
- CHUNKS=1 (W=N): a single RUN cycle, then DONE.
- Operand changes on a/b/op_sub after acceptance have no effect.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - An index-width helper constant, clog2 of CHUNKS with a minimum of 1.
- Sub-module: exactly one instance of the existing parameterised ripple adder module add, with #(N), marked keep_hierarchy.
  - It is the only arithmetic in the block.
  - Slice select, B inversion, carry flop and FSM stay in add_seq_ctrl.

Test Plan:
1. N=4, W=16. start with a=0x1234, b=0x4321, op_sub=0 -> done in cycle 5 only, result=0x5555, cout=0, ovf=0, busy high in cycles 1-5.
2. a=0xFFFF, b=0x0001, add -> result=0x0000, cout=1, ovf=0. This checks carry propagation across all 4 slices through the carry flop.
3. a=0x0005, b=0x0007, op_sub=1 -> result=0xFFFE, cout=0 (borrow), ovf=0.
4. Overflow cases:
   - a=0x7FFF, b=0x0001, add -> result=0x8000, ovf=1, cout=0.
   - a=0x8000, b=0x0001, sub -> result=0x7FFF, ovf=1, cout=1.
5. Accept 0x1111+0x2222. In cycle 2, pulse start with a=0xFFFF, b=0xFFFF -> ignored; result=0x3333 at done.
6. Reset and restart:
   - Accept an operation, then assert rst in cycle 3 -> next cycle result=0, busy=0, and done never pulses.
   - A subsequent start with 0x0001+0x0001 -> result=0x0002 at the normal latency.
   - Holding start high continuously yields a new acceptance every 6 cycles.
